// File: rtl/cell_particle_reader.sv
// Reads the particle count at address 0 of a position cell RAM, then streams records 1..count
// to a valid/ready consumer through a small FIFO whose free space gates every RAM read.
module cell_particle_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  count_err,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_rden,
  output logic                  ram_wren,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_last
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, FIN} state_t;

  state_t                state_q;
  logic                  busy_q, done_q, err_q, rden_q, wait_q, last_seen_q;
  logic [ADDR_WIDTH-1:0] cnt_q, addr_q, pid1_q, pid2_q, cnt_raw;
  logic                  v1_q, v2_q;

  logic [DATA_WIDTH-1:0] fifo_dat  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pid  [FIFO_DEPTH];
  logic                  fifo_last [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]         occ_q, occ_d;
  logic [OW+1:0]         load;
  logic                  push, pop, head_last, credit, drain_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign cnt_raw   = ram_q[ADDR_WIDTH-1:0];
  assign push      = v2_q;
  assign out_valid = (occ_q != '0);
  assign pop       = out_valid && out_ready;
  assign head_last = fifo_last[rd_ptr_q];

  always_comb begin
    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + 1'b1;
    else if (pop && !push) occ_d = occ_q - 1'b1;
  end

  // Decides next cycle's issue: that cycle will see this read, the one now in stage 1, and occ_d.
  always_comb begin
    load   = (OW+2)'(occ_d) + (OW+2)'(rden_q) + (OW+2)'(v1_q);
    credit = load < (OW+2)'(FIFO_DEPTH);
  end

  assign drain_ok = !v1_q && !v2_q && !rden_q && (occ_d == '0) &&
                    (last_seen_q || (pop && head_last));

  assign busy           = busy_q;
  assign done           = done_q;
  assign particle_count = cnt_q;
  assign count_err      = err_q;
  assign ram_address    = addr_q;
  assign ram_rden       = rden_q;
  assign ram_wren       = 1'b0;
  assign ram_data       = '0;
  assign out_data       = out_valid ? fifo_dat[rd_ptr_q] : '0;
  assign out_pid        = out_valid ? fifo_pid[rd_ptr_q] : '0;
  assign out_last       = out_valid ? head_last : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rden_q      <= 1'b0;
      wait_q      <= 1'b0;
      last_seen_q <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q     <= RD_CNT;
          busy_q      <= 1'b1;
          rden_q      <= 1'b1;
          addr_q      <= '0;
          err_q       <= 1'b0;
          last_seen_q <= 1'b0;
        end
        RD_CNT: begin
          rden_q  <= 1'b0;
          wait_q  <= 1'b0;
          state_q <= WAIT_CNT;
        end
        WAIT_CNT: begin
          if (!wait_q) begin
            wait_q <= 1'b1;
          end else begin
            if (cnt_raw > MAX_CNT) begin
              cnt_q <= MAX_CNT;
              err_q <= 1'b1;
            end else begin
              cnt_q <= cnt_raw;
            end
            if (cnt_raw == '0) begin
              state_q <= FIN;
            end else begin
              state_q <= STREAM;
              rden_q  <= 1'b1;
              addr_q  <= ADDR_WIDTH'(1);
            end
          end
        end
        STREAM: begin
          // addr_q is always the most recently issued index
          if (addr_q == cnt_q) begin
            rden_q  <= 1'b0;
            state_q <= DRAIN;
          end else if (credit) begin
            rden_q <= 1'b1;
            addr_q <= addr_q + 1'b1;
          end else begin
            rden_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (pop && head_last) last_seen_q <= 1'b1;
          if (drain_ok)         state_q     <= FIN;
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Two-stage valid/index pipe matching the RAM read latency; the count read is never tagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      pid1_q <= '0;
      pid2_q <= '0;
    end else begin
      v1_q   <= rden_q && (state_q == STREAM);
      v2_q   <= v1_q;
      pid1_q <= addr_q;
      pid2_q <= pid1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_dat[wr_ptr_q]  <= ram_q;
      fifo_pid[wr_ptr_q]  <= pid2_q;
      fifo_last[wr_ptr_q] <= (pid2_q == cnt_q);
    end
  end

endmodule

// File: tb/tb_cell_particle_reader.sv
// Directed + randomized bench: a 2-cycle RAM model feeds the reader, and a record queue built
// from the cell contents predicts the exact output stream, its timing and the done pulse.
module tb_cell_particle_reader;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, count_err, ram_rden, ram_wren;
  logic          out_valid, out_ready, out_last;
  logic [AW-1:0] particle_count, ram_address, out_pid;
  logic [DW-1:0] ram_data, ram_q, out_data;

  always #5 clk = ~clk;

  cell_particle_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .particle_count(particle_count), .count_err(count_err),
    .ram_address(ram_address), .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_data(ram_data),
    .ram_q(ram_q), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_pid(out_pid), .out_last(out_last)
  );

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rd_s1;
  always @(posedge clk) begin
    if (ram_rden) rd_s1 <= mem[ram_address];
    ram_q <= rd_s1;
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic [AW-1:0] pid;
    logic          last;
  } rec_t;

  rec_t exp_q[$];
  int vec = 0, errs = 0;
  int r, mode, stall_left, issued, accepted, done_cnt, done_r, first_v_r, busy_first, busy_last;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vec++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic observe();
    chk("ram_wren", ram_wren, 1'b0);
    if (r == 1) begin
      chk("busy at T+1", busy, 1'b1);
      chk("count read rden", ram_rden, 1'b1);
      chk("count read addr", ram_address, 0);
    end
    if (ram_rden && busy && ram_address != 0) issued++;
    if (busy) begin
      chk("outstanding<=depth", logic'((issued - accepted) <= FD), 1'b1);
      if (busy_first < 0) busy_first = r;
      busy_last = r;
    end
    if (out_valid) begin
      if (first_v_r < 0) first_v_r = r;
      if (exp_q.size() == 0) begin
        chk("spurious valid", out_valid, 1'b0);
      end else begin
        chk("out_pid", out_pid, exp_q[0].pid);
        chk("out_data", out_data, exp_q[0].d);
        chk("out_last", out_last, exp_q[0].last);
        if (out_ready) begin
          if (mode == 0) chk("record cycle", r, 6 + int'(exp_q[0].pid));
          void'(exp_q.pop_front());
          accepted++;
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_r = r;
    end
  endtask

  task automatic cyc(input logic st);
    start = st;
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = (r % 4 == 0) || (r % 4 == 3);
      2: if (out_valid && exp_q.size() > 0 && exp_q[0].pid == 3 && stall_left > 0) begin
           out_ready = 1'b0;
           stall_left--;
         end else begin
           out_ready = (r % 4 == 0) || (r % 4 == 3);
         end
      default: out_ready = 1'(($urandom % 2));
    endcase
    observe();
    @(posedge clk);
    #1;
    r++;
  endtask

  task automatic setup(input int stored, input bit pat, input int md);
    int n;
    n = (stored > PN - 1) ? PN - 1 : stored;
    mem[0] = {$urandom, $urandom, 24'($urandom), AW'(stored)};
    for (int k = 1; k < 256; k++)
      mem[k] = pat ? {32'(k + 'h300), 32'(k + 'h200), 32'(k + 'h100)}
                   : {$urandom, $urandom, $urandom};
    exp_q.delete();
    for (int k = 1; k <= n; k++) exp_q.push_back('{d: mem[k], pid: AW'(k), last: (k == n)});
    mode = md; stall_left = 20; r = 0; issued = 0; accepted = 0; done_cnt = 0;
    done_r = -1; first_v_r = -1; busy_first = -1; busy_last = -1;
  endtask

  task automatic run(input int stored, input bit pat, input int md, input int restart_r);
    int n;
    n = (stored > PN - 1) ? PN - 1 : stored;
    setup(stored, pat, md);
    cyc(1'b1);
    while (done_cnt == 0 && r < 3000) cyc(r == restart_r);
    chk("done within budget", logic'(r < 3000), 1'b1);
    repeat (3) cyc(1'b0);
    chk("exactly one done", done_cnt, 1);
    chk("all records seen", exp_q.size(), 0);
    chk("particle_count", particle_count, n);
    chk("count_err", count_err, logic'(stored > PN - 1));
    chk("idle busy", busy, 1'b0);
    chk("idle valid", out_valid, 1'b0);
    if (md == 0) chk("done cycle", done_r, (n == 0) ? 5 : 8 + n);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; mode = 0; r = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst count_err", count_err, 1'b0);
    chk("rst rden", ram_rden, 1'b0);
    chk("rst valid", out_valid, 1'b0);
    chk("rst last", out_last, 1'b0);
    chk("rst addr", ram_address, 0);
    chk("rst count", particle_count, 0);
    chk("rst data", out_data, 0);
    chk("rst pid", out_pid, 0);

    // start coinciding with reset must be dropped
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("start under rst busy", busy, 1'b0);
    chk("start under rst rden", ram_rden, 1'b0);

    run(5, 1'b1, 0, -1);
    chk("first valid cycle", first_v_r, 7);

    run(0, 1'b0, 0, -1);
    chk("count0 no valid", first_v_r, -1);
    chk("count0 busy first", busy_first, 1);
    chk("count0 busy last", busy_last, 4);

    run(10, 1'b0, 2, -1);
    run(255, 1'b0, 3, -1);

    // reset in the middle of the stream, after pid 4 has been taken
    setup(20, 1'b0, 0);
    cyc(1'b1);
    while (accepted < 4 && r < 100) cyc(1'b0);
    chk("pid4 reached", accepted, 4);
    rst = 1'b1;
    cyc(1'b0);
    rst = 1'b0;
    chk("post-rst busy", busy, 1'b0);
    chk("post-rst valid", out_valid, 1'b0);
    exp_q.delete();
    repeat (10) cyc(1'b0);
    chk("no done after rst", done_cnt, 0);
    run(7, 1'b0, 0, -1);

    // second start during STREAM is ignored; clamp state must survive it
    run(224, 1'b0, 0, 8);

    for (int i = 0; i < 3; i++) run($urandom_range(1, 30), 1'b0, 3, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
